// File: rtl/rf_exec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_exec_pkg
// Description : Shared widths, opcode and FSM state encodings for rf_exec_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package rf_exec_pkg;

    localparam int DATA_W = 2;
    localparam int ADDR_W = 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_LDI = 3'b101,
        OP_MOV = 3'b110,
        OP_NOP = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

endpackage : rf_exec_pkg
`default_nettype wire

// File: rtl/rf_exec_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : rf_exec_ctrl_if
// Description : Instruction handshake, register-file port and status bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface rf_exec_ctrl_if;
    import rf_exec_pkg::*;

    logic              instr_valid;
    logic              instr_ready;
    logic [2:0]        instr_op;
    logic [ADDR_W-1:0] instr_rd;
    logic [ADDR_W-1:0] instr_rs1;
    logic [ADDR_W-1:0] instr_rs2;
    logic [DATA_W-1:0] instr_imm;
    logic [ADDR_W-1:0] rf_raddr1;
    logic [ADDR_W-1:0] rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_we;
    logic              busy;
    logic              done;
    logic              carry_flag;
    logic              zero_flag;

    // Controller side
    modport master (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        input  rf_rdata1, rf_rdata2,
        output instr_ready, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_we,
        output busy, done, carry_flag, zero_flag
    );

    // Instruction source / register file side
    modport slave (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm,
        output rf_rdata1, rf_rdata2,
        input  instr_ready, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata, rf_we,
        input  busy, done, carry_flag, zero_flag
    );

endinterface : rf_exec_ctrl_if
`default_nettype wire

// File: rtl/alu2.sv
`default_nettype none
// ============================================================================
// Module      : alu2
// Description : Combinational ALU: (op, A, B, imm) -> (result, carry).
// Revision    : 1.0 - initial release
// ============================================================================
module alu2
    import rf_exec_pkg::*;
(
    input  opcode_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] imm,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    // MSB of the extended difference is the borrow (A < B)
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
            end
            OP_SUB: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_LDI:  result = imm;
            OP_MOV:  result = a;
            default: result = '0;
        endcase
    end

endmodule : alu2
`default_nettype wire

// File: rtl/rf_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rf_exec_ctrl
// Description : Four-state execute controller in front of the 2-entry RF.
//               Define RF_EXEC_FLAGS_EN to build the carry/zero flag registers.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_exec_ctrl
    import rf_exec_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    rf_exec_ctrl_if.master bus
);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    opcode_e           op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0] rs1_q, rs1_d;
    logic [ADDR_W-1:0] rs2_q, rs2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    alu2 u_alu2 (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .imm    (imm_q),
        .result (alu_result),
        .carry  (alu_carry)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid && ready_q) begin
                    op_d    = opcode_e'(bus.instr_op);
                    rd_d    = bus.instr_rd;
                    rs1_d   = bus.instr_rs1;
                    rs2_d   = bus.instr_rs2;
                    imm_d   = bus.instr_imm;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                a_d     = bus.rf_rdata1;
                b_d     = bus.rf_rdata2;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                result_d = alu_result;
                state_d  = ST_WRITE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Registered ready stays low through reset and rises one edge later
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ready_q  <= 1'b0;
            op_q     <= OP_ADD;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
        end
    end

    assign bus.instr_ready = ready_q;
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.done        = (state_q == ST_WRITE);
    assign bus.rf_we       = (state_q == ST_WRITE) && (op_q != OP_NOP);
    assign bus.rf_raddr1   = rs1_q;
    assign bus.rf_raddr2   = rs2_q;
    assign bus.rf_waddr    = rd_q;
    assign bus.rf_wdata    = result_q;

`ifdef RF_EXEC_FLAGS_EN
    logic carry_flag_q, carry_flag_d;
    logic zero_flag_q, zero_flag_d;

    // Loaded alongside the result so the flags are valid while done is high
    always_comb begin
        carry_flag_d = carry_flag_q;
        zero_flag_d  = zero_flag_q;
        if (state_q == ST_EXEC && op_q != OP_NOP) begin
            carry_flag_d = alu_carry;
            zero_flag_d  = (alu_result == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_flag_q <= 1'b0;
            zero_flag_q  <= 1'b0;
        end else begin
            carry_flag_q <= carry_flag_d;
            zero_flag_q  <= zero_flag_d;
        end
    end

    assign bus.carry_flag = carry_flag_q;
    assign bus.zero_flag  = zero_flag_q;
`else
    logic unused_carry;
    assign unused_carry   = alu_carry;
    assign bus.carry_flag = 1'b0;
    assign bus.zero_flag  = 1'b0;
`endif

endmodule : rf_exec_ctrl
`default_nettype wire

// File: tb/tb_rf_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_exec_ctrl
// Description : Scoreboard bench for rf_exec_ctrl with a behavioural 2-entry RF.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_exec_ctrl;
    import rf_exec_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    rf_exec_ctrl_if bus();

    rf_exec_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file seen by the controller: combinational read, commit on edge
    logic [1:0] rf_mem [2];
    always @(posedge clk) if (bus.rf_we) rf_mem[bus.rf_waddr] <= bus.rf_wdata;
    assign bus.rf_rdata1 = rf_mem[bus.rf_raddr1];
    assign bus.rf_rdata2 = rf_mem[bus.rf_raddr2];

    typedef struct {
        int cyc;
        bit we;
        int waddr;
        int wdata;
        bit carry;
        bit zero;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   ref_r[2];
    bit   ref_c    = 1'b0;
    bit   ref_z    = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Architectural model: what each instruction must write and leave in the flags
    task automatic model(input int op, input int rd, input int rs1, input int rs2, input int imm);
        exp_t e;
        int a = ref_r[rs1];
        int b = ref_r[rs2];
        int r = 0;
        bit c = 1'b0;
        case (op)
            0: begin r = (a + b) % 4; c = (a + b) > 3; end
            1: begin r = (a - b + 4) % 4; c = (a < b); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = imm;
            6: r = a;
            default: r = 0;
        endcase
        e.cyc   = cyc;
        e.we    = (op != 7);
        e.waddr = rd;
        e.wdata = r;
        if (op != 7) begin
            ref_r[rd] = r;
            ref_c     = c;
            ref_z     = (r == 0);
        end
        e.carry = ref_c;
        e.zero  = ref_z;
        sb.push_back(e);
    endtask

    task automatic send(input int op, input int rd, input int rs1, input int rs2,
                        input int imm, input bit track);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            bus.instr_valid = 1'b1;
            bus.instr_op    = op[2:0];
            bus.instr_rd    = rd[0];
            bus.instr_rs1   = rs1[0];
            bus.instr_rs2   = rs2[0];
            bus.instr_imm   = imm[1:0];
            if (bus.instr_ready) begin
                if (track) model(op, rd, rs1, rs2, imm);
                return;
            end
        end
        n_checks++;
        n_err++;
        $display("FAIL accept_timeout: instr_ready stayed 0, want 1");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.instr_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("drain_pending", sb.size(), 0);
        idle(2);
    endtask

    // Monitor: pop on every completion, then check the cycle after it
    bit   post = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (!reset) begin
            if (post) begin
                post = 1'b0;
                check("ready_after_done", bus.instr_ready, 1);
                check("busy_after_done", bus.busy, 0);
`ifdef RF_EXEC_FLAGS_EN
                check("carry_flag", bus.carry_flag, cur.carry);
                check("zero_flag", bus.zero_flag, cur.zero);
`else
                check("carry_flag", bus.carry_flag, 0);
                check("zero_flag", bus.zero_flag, 0);
`endif
            end
            if (bus.done || bus.rf_we) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_completion: done=%0d rf_we=%0d, want none",
                             bus.done, bus.rf_we);
                end else begin
                    cur = sb.pop_front();
                    check("done_with_we", bus.done, 1);
                    check("rf_we", bus.rf_we, cur.we);
                    check("latency", cyc - cur.cyc, 3);
                    check("ready_in_write", bus.instr_ready, 0);
                    if (cur.we) begin
                        check("rf_waddr", bus.rf_waddr, cur.waddr);
                        check("rf_wdata", bus.rf_wdata, cur.wdata);
                    end
                    post = 1'b1;
                end
            end
        end
    end

    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_op    = '0;
        bus.instr_rd    = '0;
        bus.instr_rs1   = '0;
        bus.instr_rs2   = '0;
        bus.instr_imm   = '0;
        ref_r[0] = 0;
        ref_r[1] = 0;

        repeat (3) @(negedge clk);
        check("rst_ready", bus.instr_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_we", bus.rf_we, 0);
        check("rst_raddr1", bus.rf_raddr1, 0);
        check("rst_raddr2", bus.rf_raddr2, 0);
        check("rst_waddr", bus.rf_waddr, 0);
        check("rst_wdata", bus.rf_wdata, 0);
        check("rst_carry", bus.carry_flag, 0);
        check("rst_zero", bus.zero_flag, 0);
        reset = 1'b0;
        #1 check("ready_before_edge", bus.instr_ready, 0);
        @(negedge clk);
        check("ready_after_edge", bus.instr_ready, 1);

        // Directed sequence, valid held high throughout (back-to-back)
        send(5, 0, 0, 0, 3, 1'b1);
        send(5, 1, 0, 0, 2, 1'b1);
        send(0, 1, 0, 1, 0, 1'b1);
        send(5, 0, 0, 0, 1, 1'b1);
        send(5, 1, 0, 0, 2, 1'b1);
        send(1, 0, 0, 1, 0, 1'b1);
        send(4, 0, 0, 0, 0, 1'b1);
        send(7, 1, 0, 1, 3, 1'b1);
        send(6, 1, 0, 0, 0, 1'b1);
        send(0, 0, 0, 1, 0, 1'b1);
        idle(1);
        drain();

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            send($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                 $urandom_range(0, 1), $urandom_range(0, 3), 1'b1);
        end
        idle(1);
        drain();

        // Interrupt an ADD in EXEC: it must never write
        send(0, 1, 0, 1, 0, 1'b0);
        @(negedge clk);
        bus.instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("irq_busy", bus.busy, 0);
        check("irq_we", bus.rf_we, 0);
        check("irq_done", bus.done, 0);
        check("irq_ready", bus.instr_ready, 0);
        ref_c = 1'b0;
        ref_z = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1 check("irq_ready_released", bus.instr_ready, 0);
        @(negedge clk);
        check("irq_ready_edge", bus.instr_ready, 1);
        check("irq_rf1_kept", rf_mem[1], ref_r[1]);
        check("irq_carry_clr", bus.carry_flag, 0);

        send(7, 0, 0, 0, 0, 1'b1);
        send(0, 1, 0, 1, 0, 1'b1);
        send(1, 0, 1, 0, 0, 1'b1);
        idle(1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_rf_exec_ctrl
`default_nettype wire
